// File: rtl/word_gen_pkg.sv
// Shared types and constants for the character-range word generator.
package word_gen_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  localparam int CHARS_NUMBER_MAX_7 = 96;
  localparam int CHARS_NUMBER_MAX_8 = 224;

  function automatic int chars_number_max(input int char_bits);
    return (char_bits == 7) ? CHARS_NUMBER_MAX_7 : CHARS_NUMBER_MAX_8;
  endfunction

  // Index/count fields must hold 0..CHARS_NUMBER_MAX inclusive.
  function automatic int num_w(input int char_bits);
    return $clog2(chars_number_max(char_bits) + 1);
  endfunction

endpackage

// File: rtl/word_gen_char_range_bidir_if.sv
// Configuration / operation / output bundle of one generator position.
interface word_gen_char_range_bidir_if #(
  parameter int CHAR_BITS = 7
);
  import word_gen_pkg::*;

  localparam int NUM_W = num_w(CHAR_BITS);

  logic [CHAR_BITS-1:0] din;
  logic                 conf_en_chars;
  logic [NUM_W-1:0]     conf_char_addr;
  logic                 conf_en_num_chars;
  logic [NUM_W-1:0]     conf_num_chars;
  logic                 conf_dir;
  logic                 conf_en_start_idx;
  logic [NUM_W-1:0]     conf_start_idx;
  logic                 op_start;
  logic                 op_next;
  logic                 carry_in;
  logic                 carry;
  logic [CHAR_BITS-1:0] dout;
  logic                 dout_valid;

  modport master (
    output din, conf_en_chars, conf_char_addr, conf_en_num_chars, conf_num_chars,
           conf_dir, conf_en_start_idx, conf_start_idx, op_start, op_next, carry_in,
    input  carry, dout, dout_valid
  );

  modport slave (
    input  din, conf_en_chars, conf_char_addr, conf_en_num_chars, conf_num_chars,
           conf_dir, conf_en_start_idx, conf_start_idx, op_start, op_next, carry_in,
    output carry, dout, dout_valid
  );

endinterface

// File: rtl/word_gen_char_ram.sv
// Simple dual-port character store: one write port, one registered read port
// with read enable and a synchronous clear of the output register.
module word_gen_char_ram #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read samples the array before the same-edge write lands: old data wins.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/word_gen_char_range_bidir.sv
// One position of a word generator stepping through a configurable character range.
// Define WORD_GEN_EXTRA_REGISTER_STAGE_EN to add an output register stage (latency 2).
module word_gen_char_range_bidir
  import word_gen_pkg::*;
#(
  parameter int CHAR_BITS = 7
) (
  input logic                        clk,
  input logic                        rst,
  word_gen_char_range_bidir_if.slave bus
);

  localparam int NUM_W = num_w(CHAR_BITS);

  state_e               state_q, state_d;
  logic [NUM_W-1:0]     idx_q, idx_d;
  logic [NUM_W-1:0]     start_idx_q, start_idx_d;
  logic [NUM_W-1:0]     num_chars_q, num_chars_d;
  logic                 dir_q, dir_d;
  logic                 carry_q, carry_d;
  logic                 valid_q, valid_d;
  logic [NUM_W-1:0]     last_idx;
  logic                 cfg_blk;
  logic                 step_req;
  logic                 next_ok;
  logic                 rd_en;
  logic                 rd_clr;
  logic [CHAR_BITS-1:0] ram_rdata;

  assign last_idx = num_chars_q - 1'b1;
  assign cfg_blk  = bus.conf_en_num_chars | bus.conf_en_start_idx;
  assign step_req = bus.op_next & bus.carry_in & next_ok;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_idx_d = start_idx_q;
    num_chars_d = num_chars_q;
    dir_d       = dir_q;
    carry_d     = carry_q;
    valid_d     = valid_q;
    rd_en       = 1'b0;
    rd_clr      = 1'b0;

    if (bus.conf_en_start_idx) begin
      start_idx_d = bus.conf_start_idx;
    end

    if (bus.conf_en_num_chars) begin
      num_chars_d = bus.conf_num_chars;
      dir_d       = bus.conf_dir;
      valid_d     = 1'b0;
      if (bus.conf_num_chars == '0) begin
        state_d = EMPTY;
        rd_clr  = 1'b1;
      end else begin
        state_d = READY;
      end
    end else if (!cfg_blk) begin
      if (bus.op_start) begin
        // An empty range is transparent: it only raises valid.
        carry_d = 1'b0;
        valid_d = 1'b1;
        if (state_q != EMPTY) begin
          state_d = RUN;
          rd_en   = 1'b1;
          idx_d   = (start_idx_q >= num_chars_q) ? '0 : start_idx_q;
        end
      end else if (step_req) begin
        case (state_q)
          EMPTY: carry_d = 1'b1;
          RUN: begin
            rd_en = 1'b1;
            if (dir_q == DIR_ASC) begin
              carry_d = (idx_q == last_idx);
              idx_d   = (idx_q == last_idx) ? '0 : idx_q + 1'b1;
            end else begin
              carry_d = (idx_q == '0);
              idx_d   = (idx_q == '0) ? last_idx : idx_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      idx_q       <= '0;
      start_idx_q <= '0;
      num_chars_q <= '0;
      dir_q       <= DIR_ASC;
      carry_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_idx_q <= start_idx_d;
      num_chars_q <= num_chars_d;
      dir_q       <= dir_d;
      carry_q     <= carry_d;
      valid_q     <= valid_d;
    end
  end

  // The read port registers dout; addressing with idx_d gives one-cycle latency.
  word_gen_char_ram #(
    .DATA_W (CHAR_BITS),
    .ADDR_W (NUM_W)
  ) u_char_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.conf_en_chars),
    .waddr (bus.conf_char_addr),
    .wdata (bus.din),
    .re    (rd_en),
    .raddr (idx_d),
    .clr   (rd_clr),
    .rdata (ram_rdata)
  );

`ifdef WORD_GEN_EXTRA_REGISTER_STAGE_EN
  logic                 start_q, start_d;
  logic                 adv_q, adv_d;
  logic [CHAR_BITS-1:0] dout_q, dout_d;
  logic                 carry_out_q, carry_out_d;
  logic                 valid_out_q, valid_out_d;

  // The second stage reloads the cycle after anything that changed the first.
  always_comb begin
    start_d     = bus.op_start & ~cfg_blk;
    adv_d       = start_d | bus.conf_en_num_chars
                | (bus.op_next & bus.carry_in & ~cfg_blk & ~bus.op_start);
    dout_d      = dout_q;
    carry_out_d = carry_out_q;
    valid_out_d = valid_out_q;
    if (adv_q) begin
      dout_d      = ram_rdata;
      carry_out_d = carry_q;
      valid_out_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      adv_q       <= 1'b0;
      dout_q      <= '0;
      carry_out_q <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      start_q     <= start_d;
      adv_q       <= adv_d;
      dout_q      <= dout_d;
      carry_out_q <= carry_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign next_ok        = ~start_q;
  assign bus.dout       = dout_q;
  assign bus.carry      = carry_out_q;
  assign bus.dout_valid = valid_out_q;
`else
  assign next_ok        = 1'b1;
  assign bus.dout       = ram_rdata;
  assign bus.carry      = carry_q;
  assign bus.dout_valid = valid_q;
`endif

endmodule

// File: tb/tb_word_gen_char_range_bidir.sv
// Bench for word_gen_char_range_bidir: vector table, directed corner cases and a
// randomized run against a transaction-level model.
module tb_word_gen_char_range_bidir;

  localparam int CB = 7;
`ifdef WORD_GEN_EXTRA_REGISTER_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [6:0] CA = 7'h61;
  localparam logic [6:0] CBB = 7'h62;
  localparam logic [6:0] CC = 7'h63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_gen_char_range_bidir_if #(.CHAR_BITS(CB)) bus ();
  word_gen_char_range_bidir #(.CHAR_BITS(CB)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       en_chars;
    logic [6:0] addr;
    logic [6:0] din;
    logic       en_num;
    logic [6:0] num;
    logic       dir;
    logic       en_si;
    logic [6:0] si;
    logic       start;
    logic       next;
    logic       cin;
  } txn_t;

  typedef struct {
    txn_t       t;
    logic [6:0] d;
    logic       c;
    logic       v;
  } vec_t;

  int total = 0;
  int bad = 0;

  // Reference model: range position as plain integers, state as 0=empty 1=ready 2=run.
  logic [6:0] m_ram [128];
  int         m_mode, m_idx, m_si, m_num;
  logic       m_dir, m_carry, m_valid;
  logic [6:0] m_dout;

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_si = 0; m_num = 0; m_dir = 1'b0;
    m_dout = '0; m_carry = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step(input txn_t t);
    if (t.en_si) m_si = int'(t.si);
    if (t.en_num) begin
      m_num = int'(t.num);
      m_dir = t.dir;
      m_valid = 1'b0;
      m_mode = (m_num == 0) ? 0 : 1;
      if (m_num == 0) m_dout = '0;
    end else if (!t.en_si) begin
      if (t.start) begin
        m_valid = 1'b1;
        m_carry = 1'b0;
        if (m_mode != 0) begin
          m_idx = (m_si < m_num) ? m_si : 0;
          m_mode = 2;
          m_dout = m_ram[m_idx];
        end
      end else if (t.next && t.cin) begin
        if (m_mode == 0) begin
          m_carry = 1'b1;
        end else if (m_mode == 2) begin
          if (!m_dir) begin
            m_carry = (m_idx + 1 == m_num);
            m_idx = (m_idx + 1) % m_num;
          end else begin
            m_carry = (m_idx == 0);
            m_idx = (m_idx + m_num - 1) % m_num;
          end
          m_dout = m_ram[m_idx];
        end
      end
    end
    if (t.en_chars) m_ram[t.addr] = t.din;
  endtask

  function automatic txn_t blank();
    txn_t t;
    t.en_chars = 0; t.addr = '0; t.din = '0; t.en_num = 0; t.num = '0; t.dir = 0;
    t.en_si = 0; t.si = '0; t.start = 0; t.next = 0; t.cin = 0;
    return t;
  endfunction

  function automatic txn_t cfg(input int num, input logic dir, input logic en_si, input int si);
    txn_t t = blank();
    t.en_num = 1; t.num = 7'(num); t.dir = dir; t.en_si = en_si; t.si = 7'(si);
    return t;
  endfunction

  function automatic txn_t op(input logic start, input logic next, input logic cin);
    txn_t t = blank();
    t.start = start; t.next = next; t.cin = cin;
    return t;
  endfunction

  function automatic txn_t wr(input int a, input int d);
    txn_t t = blank();
    t.en_chars = 1; t.addr = 7'(a); t.din = 7'(d);
    return t;
  endfunction

  function automatic vec_t mk(input txn_t t, input int d, input logic c, input logic v);
    vec_t r;
    r.t = t; r.d = 7'(d); r.c = c; r.v = v;
    return r;
  endfunction

  task automatic put(input txn_t t);
    bus.conf_en_chars     = t.en_chars;
    bus.conf_char_addr    = t.addr;
    bus.din               = t.din;
    bus.conf_en_num_chars = t.en_num;
    bus.conf_num_chars    = t.num;
    bus.conf_dir          = t.dir;
    bus.conf_en_start_idx = t.en_si;
    bus.conf_start_idx    = t.si;
    bus.op_start          = t.start;
    bus.op_next           = t.next;
    bus.carry_in          = t.cin;
  endtask

  // Called at a falling edge; returns at a falling edge with outputs settled.
  task automatic run(input txn_t t);
    put(t);
    @(negedge clk);
    put(blank());
    model_step(t);
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int d, input int c, input int v);
    $display("%s: dout=%02h carry=%0b valid=%0b", tag, bus.dout, bus.carry, bus.dout_valid);
    chk({tag, " dout"}, int'(bus.dout), d);
    chk({tag, " carry"}, int'(bus.carry), c);
    chk({tag, " valid"}, int'(bus.dout_valid), v);
  endtask

  vec_t vecs[$];

  initial begin
    txn_t t;

    put(blank());
    model_reset();
    repeat (3) @(negedge clk);
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 128; a++) begin
      run(wr(a, (a < 3) ? (int'(CA) + a) : int'($urandom_range(0, 127))));
    end

    // Ascending wrap, descending wrap, bad start index, abort, num=1, num=0, priority.
    vecs.push_back(mk(cfg(3, 0, 1, 1), 0, 0, 0));
    vecs.push_back(mk(op(1, 0, 0), CBB, 0, 1));
    vecs.push_back(mk(op(0, 1, 1), CC, 0, 1));
    vecs.push_back(mk(op(0, 1, 1), CA, 1, 1));
    vecs.push_back(mk(op(0, 1, 1), CBB, 0, 1));
    vecs.push_back(mk(cfg(3, 1, 1, 0), CBB, 0, 0));
    vecs.push_back(mk(op(1, 0, 0), CA, 0, 1));
    vecs.push_back(mk(op(0, 1, 1), CC, 1, 1));
    vecs.push_back(mk(op(0, 1, 1), CBB, 0, 1));
    vecs.push_back(mk(cfg(3, 0, 1, 7), CBB, 0, 0));
    vecs.push_back(mk(op(1, 0, 0), CA, 0, 1));
    vecs.push_back(mk(cfg(3, 0, 0, 0), CA, 0, 0));
    vecs.push_back(mk(op(0, 1, 1), CA, 0, 0));
    vecs.push_back(mk(cfg(1, 0, 1, 0), CA, 0, 0));
    vecs.push_back(mk(op(1, 0, 0), CA, 0, 1));
    vecs.push_back(mk(op(0, 1, 1), CA, 1, 1));
    vecs.push_back(mk(op(0, 1, 1), CA, 1, 1));
    vecs.push_back(mk(cfg(0, 0, 0, 0), 0, 1, 0));
    vecs.push_back(mk(op(1, 0, 0), 0, 0, 1));
    vecs.push_back(mk(op(0, 1, 1), 0, 1, 1));
    t = cfg(3, 0, 0, 0);
    t.start = 1;
    vecs.push_back(mk(t, 0, 1, 0));
    vecs.push_back(mk(op(0, 1, 1), 0, 1, 0));

    foreach (vecs[i]) begin
      run(vecs[i].t);
      chk_out($sformatf("vec %0d", i), vecs[i].d, vecs[i].c, vecs[i].v);
    end

    // Hold: op_next without carry_in for 5 cycles after a descending wrap.
    run(cfg(3, 1, 1, 0));
    run(op(1, 0, 0));
    run(op(0, 1, 1));
    chk_out("hold setup", CC, 1, 1);
    put(op(0, 1, 0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_out($sformatf("hold %0d", k), CC, 1, 1);
    end
    put(blank());
    @(negedge clk);

    // Write to the address being read in the same cycle returns the old data.
    run(cfg(3, 0, 1, 0));
    run(op(1, 0, 0));
    t = op(0, 1, 1);
    t.en_chars = 1; t.addr = 7'd1; t.din = 7'h7a;
    run(t);
    chk_out("rdw old data", CBB, 0, 1);
    run(cfg(3, 0, 1, 1));
    run(op(1, 0, 0));
    chk_out("rdw new data", 7'h7a, 0, 1);
    run(wr(1, CBB));

    // Latency from op_start.
    run(cfg(3, 0, 1, 2));
    put(op(1, 0, 0));
    @(negedge clk);
    put(blank());
    chk("latency first cycle valid", int'(bus.dout_valid), (LAT == 1) ? 1 : 0);
    model_step(op(1, 0, 0));
    repeat (LAT - 1) @(negedge clk);
    chk_out("latency settled", CC, 0, 1);

    for (int i = 0; i < 200; i++) begin
      t = blank();
      if ($urandom_range(0, 4) == 0) begin
        t.en_chars = 1; t.addr = 7'($urandom_range(0, 127)); t.din = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 11) == 0) begin
        t.en_num = 1;
        t.num = 7'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 96) : $urandom_range(0, 4));
        t.dir = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) begin
        t.en_si = 1; t.si = 7'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 5));
      end
      t.start = ($urandom_range(0, 6) == 0);
      t.next = ($urandom_range(0, 9) < 6);
      t.cin = ($urandom_range(0, 9) < 7);
      run(t);
      chk_out($sformatf("rnd %0d", i), m_dout, m_carry, m_valid);
    end

    // Asynchronous reset between clock edges during a run.
    run(cfg(3, 0, 1, 1));
    run(op(1, 0, 0));
    chk_out("pre-reset", CBB, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk_out("async reset", 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(op(1, 0, 0));
    chk_out("post-reset start", 0, 0, 1);
    run(op(0, 1, 1));
    chk_out("post-reset step", 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_gen_char_range_bidir.md
WORD_GEN_CHAR_RANGE_BIDIR -- requirements
Module: word_gen_char_range_bidir

Interface
REQ-001 CHAR_BITS, 7, character width; legal values 7 and 8.
REQ-002 CHARS_NUMBER_MAX, 96 if CHAR_BITS==7 else 224, maximum number of characters in the range.
REQ-003 NUM_CHARS_MSB, MSB(CHARS_NUMBER_MAX), MSB of index and count fields.
REQ-004 CLK  in  1  single clock; configuration and generation both run on it.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 din  in  CHAR_BITS  character data, written with conf_en_chars.
REQ-007 conf_en_chars  in  1  write din at conf_char_addr.
REQ-008 conf_char_addr  in  NUM_CHARS_MSB+1  character RAM write address.
REQ-009 conf_en_num_chars  in  1  latch conf_num_chars and conf_dir.
REQ-010 conf_num_chars  in  NUM_CHARS_MSB+1  character count, 0..CHARS_NUMBER_MAX.
REQ-011 conf_dir  in  1  0 = ascending, 1 = descending.
REQ-012 conf_en_start_idx  in  1  latch conf_start_idx.
REQ-013 conf_start_idx  in  NUM_CHARS_MSB+1  starting index.
REQ-014 op_start  in  1  load the start index and emit the first character.
REQ-015 op_next  in  1  step request; effective only when carry_in=1.
REQ-016 carry_in  in  1  carry from the less-significant position.
REQ-017 carry  out  1  asserted when the last step wrapped.
REQ-018 dout  out  CHAR_BITS  current character.
REQ-019 dout_valid  out  1  dout and carry are valid.

Function
REQ-020 The block SHALL use three states:
- EMPTY: num_chars == 0.
- READY: configured, not started.
- RUN: generating.
REQ-021 conf_en_num_chars SHALL move the block to EMPTY if conf_num_chars == 0, else to READY, from any state (this aborts RUN).
REQ-022 op_start in READY or RUN SHALL:
- load idx from start_idx, using 0 if start_idx >= num_chars;
- move the block to RUN;
- deassert carry.
REQ-023 A step SHALL occur when op_next & carry_in in RUN.
- Ascending: idx increments and wraps from num_chars-1 to 0.
- Descending: idx decrements and wraps from 0 to num_chars-1.
REQ-024 carry SHALL update only on a step.
- It is 1 when the step wrapped, else 0.
- If num_chars == 1, every step gives carry = 1 and dout is unchanged.
REQ-025 When op_next & carry_in are not both asserted, idx, dout and carry SHALL hold.
REQ-026 dout SHALL equal RAM[idx] 1 cycle after op_start or a step (read latency 1).
- dout_valid SHALL assert on that same cycle and stay high while in RUN.
REQ-027 In EMPTY:
- dout SHALL be 0;
- op_start SHALL raise dout_valid, so the position is transparent;
- every op_next & carry_in SHALL give carry = 1.
REQ-028 Configuration strobes SHALL take priority over op_start and op_next in the same cycle; the op strobe is ignored.
REQ-029 A RAM write to the address being read in the same cycle SHALL return the old data.

Reset
REQ-030 RST SHALL asynchronously set:
- state = EMPTY;
- idx = 0, start_idx = 0, num_chars = 0, dir = 0;
- dout = 0, carry = 0, dout_valid = 0.
REQ-031 RAM contents SHALL NOT be reset; they are undefined until written.
REQ-032 RST asserted mid-RUN SHALL discard the sequence; a fresh configuration is required.

Configuration
REQ-033 With WORD_GEN_EXTRA_REGISTER_STAGE_EN defined:
- dout, carry and dout_valid SHALL pass through one extra register enabled on start/step;
- latency becomes 2 cycles;
- op_next SHALL be ignored for 1 cycle after op_start.
REQ-034 Without the macro, latency SHALL be 1 cycle and there is no extra register.

Structure
REQ-035 A shared package word_gen_pkg SHALL hold:
- the state enum (EMPTY/READY/RUN);
- the DIR_ASC/DIR_DESC constants;
- the default CHARS_NUMBER_MAX values.
REQ-036 The character store SHALL be a sub-module word_gen_char_ram.
- Single-clock simple dual-port block RAM, width CHAR_BITS, depth 2**CHAR_BITS.
- Synchronous read with read enable; output reset by EMPTY.

Verification
REQ-037 Ascending wrap: chars "abc", num=3, start=1, asc.
- Stimulus: op_start, then 3 steps with carry_in=1.
- Required: dout b,c,a,b; carry 0,1,0.
REQ-038 Descending wrap: same range, dir=1, start=0.
- Stimulus: 2 steps.
- Required: dout a,c,b; carry 1,0.
REQ-039 Hold and edge counts:
- carry_in=0 with op_next for 5 cycles: dout and carry unchanged.
- num=1: every step gives carry=1.
- num=0: dout=0 and carry=1.
REQ-040 Bad start index: start_idx=7 with num=3.
- Required: first dout = RAM[0].
- conf_en_num_chars mid-RUN -> state READY, dout_valid=0.
REQ-041 Async reset: RST pulsed between clock edges during RUN.
- Required: outputs zero immediately.
- Repeated with WORD_GEN_EXTRA_REGISTER_STAGE_EN to confirm 2-cycle latency.
